imem_responder: RTL

- Instruction-memory responder: the serving end of the fetch request/response interface.
- Accepts word fetch requests from the fetch stage and returns instruction words one cycle later through a 2-entry response buffer.
- Flags misaligned and out-of-range addresses and drops in-flight responses on a pipeline flush.
- Also exposes a word write port so the UART boot loader can fill memory before or between runs.

---
 rtl/imem_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch request/response port with a 2-entry response buffer
// and a boot-loader word write port. Optional per-word parity: define IMEM_PARITY_EN.
module imem_responder #(
  parameter int                   BUS_WIDTH = 32,
  parameter int                   ADDR      = 12,
  parameter logic [BUS_WIDTH-1:0] NOP_INST  = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BUS_WIDTH-1:0] req_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_inst,
  output logic [2:0]           resp_err,
  input  logic                 flush,
  input  logic                 load_we,
  input  logic [ADDR-3:0]      load_addr,
  input  logic [BUS_WIDTH-1:0] load_data,
  output logic                 load_busy
);

  localparam int DEPTH = 2**(ADDR-2);

  typedef struct packed {
    logic [BUS_WIDTH-1:0] inst;
    logic [2:0]           err;
  } ent_t;

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  ent_t                 e0_q, e0_d, e1_q, e1_d, new_ent;
  logic [1:0]           cnt_q, cnt_d, occ_after;
  logic                 busy_q;
  logic                 pop, push, mis, flt, perr;
  logic [BUS_WIDTH-1:0] rd_word;

  // The memory read happens at the accepting edge, so an accepted request lands
  // directly in the buffer: occupancy is simply the buffer count.
  assign resp_valid = (cnt_q != 2'd0);
  assign pop        = resp_valid & resp_ready;
  assign occ_after  = cnt_q - {1'b0, pop};
  assign load_busy  = busy_q | (load_we & rst);
  assign req_ready  = !load_we && !load_busy && !flush && (occ_after < 2'd2);
  assign push       = req_valid & req_ready;

  assign resp_inst  = resp_valid ? e0_q.inst : NOP_INST;
  assign resp_err   = resp_valid ? e0_q.err  : 3'b000;

  assign mis     = |req_addr[1:0];
  assign flt     = |req_addr[BUS_WIDTH-1:ADDR];
  assign rd_word = mem[req_addr[ADDR-1:2]];

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (load_we) par_mem[load_addr] <= ^load_data;
  end
  assign perr = !mis && !flt && ((^rd_word) != par_mem[req_addr[ADDR-1:2]]);
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  always_comb begin
    new_ent.err  = {perr, flt, mis};
    new_ent.inst = (mis || flt || perr) ? NOP_INST : rd_word;
  end

  // Shift-style FIFO: entry 0 is always the head.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = new_ent;
          else               e1_d = new_ent;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_d = new_ent;
          end else begin
            e0_d = e1_q;
            e1_d = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 2'd0;
      e0_q   <= '{inst: NOP_INST, err: 3'b000};
      e1_q   <= '{inst: NOP_INST, err: 3'b000};
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      e0_q   <= e0_d;
      e1_q   <= e1_d;
      busy_q <= load_we;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && cnt_q == 2'd2));

endmodule
